// File: rtl/trig_pulse_gen_pkg.sv
// Shared definitions for the trigger-to-pulse generator: FSM state encoding
// and the default counter width.
package trig_pulse_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module load_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/trig_pulse_gen.sv
// Turns a one-cycle trigger strobe into a pulse with programmable delay,
// width and re-arm holdoff; reports completion (done) and dropped triggers (miss).
module trig_pulse_gen
  import trig_pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] holdoff,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic             miss
);

  state_t           state;
  logic [CNT_W-1:0] w_m1;
  logic [CNT_W-1:0] h_lat;
  logic [CNT_W-1:0] w_in_m1;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  // Width 0 behaves as 1, so the high-phase load value is max(width,1)-1.
  assign w_in_m1 = (width == '0) ? '0 : (width - CNT_W'(1));

  load_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (abort) begin
      cnt_load = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            cnt_load = 1'b1;
            cnt_val  = (delay == '0) ? w_in_m1 : (delay - CNT_W'(1));
          end
        end
        DELAY: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = w_m1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = (h_lat == '0) ? '0 : (h_lat - CNT_W'(1));
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: cnt_dec = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y     <= 1'b0;
      done  <= 1'b0;
      miss  <= 1'b0;
      w_m1  <= '0;
      h_lat <= '0;
    end else begin
      done <= 1'b0;
      miss <= 1'b0;
      if (abort) begin
        state <= IDLE;
        y     <= 1'b0;
      end else begin
        // Any trig outside IDLE is dropped, including on the return-to-IDLE edge.
        miss <= trig && (state != IDLE);
        case (state)
          IDLE: begin
            if (trig) begin
              w_m1  <= w_in_m1;
              h_lat <= holdoff;
              if (delay == '0) begin
                state <= HIGH;
                y     <= 1'b1;
              end else begin
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (cnt_zero) begin
              state <= HIGH;
              y     <= 1'b1;
            end
          end
          HIGH: begin
            if (cnt_zero) begin
              y     <= 1'b0;
              done  <= 1'b1;
              state <= (h_lat != '0) ? HOLD : IDLE;
            end
          end
          default: begin
            if (cnt_zero) begin
              state <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/trig_pulse_gen.md
# trig_pulse_gen

Converts a single-cycle trigger strobe into a clean output pulse with programmable delay, width and re-arm holdoff. It is the generating counterpart of the team's edge detectors: detectors turn level edges into one-cycle strobes, and this block turns one-cycle strobes back into timed level edges. It sits between the control/strobe logic and the DE0 pulse output pins. It also reports completion and dropped triggers back to the control side.

## Interface
Parameters:
- CNT_W, 16, width of the delay/width/holdoff counts and of the internal counter.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- trig  input  1  one-cycle trigger strobe, synchronous to clk.
- abort  input  1  synchronous cancel of any pulse in progress.
- delay  input  CNT_W  cycles from trigger acceptance to rising edge of y; sampled only on an accepted trig.
- width  input  CNT_W  high time of y in cycles; 0 is treated as 1; sampled only on an accepted trig.
- holdoff  input  CNT_W  dead cycles after the falling edge of y before re-arm; sampled only on an accepted trig.
- y  output  1  generated pulse, registered.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle strobe in the first cycle y is low after a completed pulse.
- miss  output  1  one-cycle strobe: a trig arrived while busy and was dropped.

## Operation
- States: IDLE, DELAY, HIGH, HOLD. There is one down-counter, cnt.
- IDLE with trig=1:
  - Latch delay (d), width (w, clamped to at least 1) and holdoff (h).
  - If d=0: go to HIGH, set y<=1, load cnt<=w-1.
  - Otherwise: go to DELAY, load cnt<=d-1.
- DELAY:
  - If cnt=0: go to HIGH, set y<=1, load cnt<=w-1.
  - Otherwise: decrement cnt.
- HIGH:
  - If cnt=0: set y<=0 and done<=1. If h>0, go to HOLD with cnt<=h-1; otherwise go to IDLE.
  - Otherwise: decrement cnt.
- HOLD:
  - If cnt=0: go to IDLE.
  - Otherwise: decrement cnt.
- Dropped triggers: trig sampled in any state other than IDLE is ignored and sets miss<=1 for one cycle. This includes the edge on which the FSM returns to IDLE. The running pulse is unaffected.
- abort=1 at any edge:
  - Go to IDLE, set y<=0, set cnt<=0.
  - done is not asserted.
  - abort has priority over trig; a simultaneous trig is dropped without miss.
- Changes on delay, width or holdoff after acceptance have no effect until the next accepted trig.
- Reset value of every output is 0: y=0, busy=0, done=0, miss=0. State is IDLE, cnt=0.
- Reset mid-pulse drops y immediately (asynchronously) and asserts no done.

## Timing
- Trigger accepted at edge k:
  - y rises after edge k+d (latency d+1 cycles from the trig cycle).
  - y stays high exactly w cycles and falls after edge k+d+w.
  - done is high for the cycle following edge k+d+w.
- busy rises after edge k and falls after edge k+d+w+h.
- Minimum trig-to-trig period for acceptance is d+w+h+1 cycles. y is always low for at least one cycle between pulses.
- miss is registered: it appears one cycle after the dropped trig.
- Counter arithmetic is unsigned, CNT_W bits, and never wraps. Loads happen only from the clamped values above, so no load underflows.
- Maximum pulse width is 2^CNT_W-1 cycles; maximum delay and holdoff are each 2^CNT_W-1 cycles.

## Structure
- Shared package trig_pulse_gen_pkg holds:
  - the state encoding, as an enum IDLE/DELAY/HIGH/HOLD, binary-encoded;
  - the CNT_W default constant.
- One sub-module, load_down_counter (CNT_W wide, with load, load value, decrement enable and a zero flag). It is instantiated once and shared across DELAY, HIGH and HOLD.
- The FSM, the output registers and the clamp logic stay in the top module.

## Test plan
- Reset/idle:
  - Stimulus: assert rst mid-pulse (d=2, w=5, y high).
  - Required response: y, busy, done and miss go to 0 immediately; no done after rst is released.
- Basic pulse:
  - Stimulus: d=3, w=4, h=2, trig at edge 10.
  - Required response: y high after edges 13..16 and low after edge 17; done high in the cycle after edge 17; busy low after edge 19.
- Zero values:
  - Stimulus: d=0, w=0, h=0, trig at edge 5.
  - Required response: y high for exactly one cycle after edge 5; done after edge 6; busy low after edge 6.
- Dropped trigger:
  - Stimulus: d=1, w=3, h=1 with trig at edges 0, 2 and 5.
  - Required response: trigs at edges 2 and 5 each produce one miss cycle; only one pulse appears. A trig at edge 6 is accepted.
- Abort:
  - Stimulus: d=0, w=10, trig at edge 0, abort at edge 4.
  - Required response: y low after edge 4; no done; busy low after edge 4; a new trig at edge 5 is accepted.
- Max counts:
  - Stimulus: CNT_W=4, d=15, w=15, h=15.
  - Required response: y rises after edge k+15, is high 15 cycles, and busy falls after edge k+45, with no counter wrap.
